// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the PIO input blocks: register offsets, edge/IRQ mode
// encodings and the post-reset arming state.
package soc_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

  typedef enum logic {
    ARM_ARMING = 1'b0,
    ARM_ARMED  = 1'b1
  } arm_state_t;

endpackage

// File: rtl/soc_system_sync_vec.sv
// WIDTH-bit multi-flop synchroniser for asynchronous fabric inputs.
// The last stage is the synchronised value.
module soc_system_sync_vec #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/soc_system_pio_in_irq.sv
// Avalon-MM input PIO: synchronised inputs, per-bit sticky edge capture
// (W1C) and a maskable level- or edge-driven interrupt.
//
// arm state  | meaning
// ARM_ARMING | counting out the synchroniser fill; edge detection suppressed
// ARM_ARMED  | edge detection live until the next reset
module soc_system_pio_in_irq
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_MODE    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);

  logic [WIDTH-1:0] w_data_in;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_det;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_wr_data;
  logic [31:0]      w_rd_mux;
  logic             w_wr;
  logic             w_armed;
  logic             w_irq_next;
  logic             w_unused_wdata;

  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic [31:0]      r_readdata;
  logic             r_irq;
  arm_state_t       r_arm_state;
  logic [ARM_W-1:0] r_arm_cnt;

  soc_system_sync_vec #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (in_port),
    .o_q   (w_data_in)
  );

  always_comb begin
    w_edge = '0;
    case (EDGE_TYPE)
      EDGE_FALL: w_edge = ~w_data_in & r_prev;
      EDGE_ANY:  w_edge = w_data_in ^ r_prev;
      default:   w_edge = w_data_in & ~r_prev;
    endcase
  end

  assign w_armed        = (r_arm_state == ARM_ARMED);
  assign w_det          = w_armed ? w_edge : '0;
  assign w_wr           = chipselect & ~write_n;
  assign w_wr_data      = writedata[WIDTH-1:0];
  assign w_clr          = (w_wr && address == ADDR_EDGECAP) ? w_wr_data : '0;
  assign w_unused_wdata = ^writedata;

  always_comb begin
    if (IRQ_MODE == IRQ_LEVEL) w_irq_next = |(w_data_in & r_mask);
    else                       w_irq_next = |(r_cap & r_mask);
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:    w_rd_mux[WIDTH-1:0] = w_data_in;
      ADDR_IRQMASK: w_rd_mux[WIDTH-1:0] = r_mask;
      ADDR_EDGECAP: w_rd_mux[WIDTH-1:0] = r_cap;
      default:      ;
    endcase
  end

  // Holds off capture until the chain and prev hold real post-reset samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_arm_state <= ARM_ARMING;
      r_arm_cnt   <= '0;
    end else if (r_arm_state == ARM_ARMING) begin
      r_arm_cnt <= r_arm_cnt + ARM_W'(1);
      if (r_arm_cnt == ARM_LAST) r_arm_state <= ARM_ARMED;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev     <= '0;
      r_mask     <= '0;
      r_cap      <= '0;
      r_irq      <= 1'b0;
      r_readdata <= '0;
    end else begin
      r_prev <= w_data_in;
      if (w_wr && address == ADDR_IRQMASK) r_mask <= w_wr_data;
      // A fresh edge outranks a same-cycle clear so no event is lost.
      r_cap      <= (r_cap & ~w_clr) | w_det;
      r_irq      <= w_irq_next;
      r_readdata <= chipselect ? w_rd_mux : '0;
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_soc_system_pio_in_irq.sv
// Scoreboard bench for soc_system_pio_in_irq: three instances cover rising/edge,
// level IRQ, and 1-bit any-edge configurations.
module tb_soc_system_pio_in_irq;
  import soc_system_pio_pkg::*;

  typedef struct {
    int          d;
    bit          is_irq;
    logic [31:0] exp;
    int          due;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  addr  [3];
  logic        cs    [3];
  logic        wn    [3];
  logic [31:0] wd    [3];
  logic [31:0] rdata [3];
  logic        irq   [3];
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [0:0]  in_c;

  exp_t q[$];
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   c0;

  soc_system_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_RISE), .IRQ_MODE(IRQ_EDGE)) u_a (
    .clk(clk), .reset(rst), .address(addr[0]), .chipselect(cs[0]), .write_n(wn[0]),
    .writedata(wd[0]), .in_port(in_a), .readdata(rdata[0]), .irq(irq[0]));

  soc_system_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_RISE), .IRQ_MODE(IRQ_LEVEL)) u_b (
    .clk(clk), .reset(rst), .address(addr[1]), .chipselect(cs[1]), .write_n(wn[1]),
    .writedata(wd[1]), .in_port(in_b), .readdata(rdata[1]), .irq(irq[1]));

  soc_system_pio_in_irq #(.WIDTH(1), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_ANY), .IRQ_MODE(IRQ_EDGE)) u_c (
    .clk(clk), .reset(rst), .address(addr[2]), .chipselect(cs[2]), .write_n(wn[2]),
    .writedata(wd[2]), .in_port(in_c), .readdata(rdata[2]), .irq(irq[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input bit is_irq, input logic [31:0] exp, input int due,
                      input string name);
    exp_t e;
    e.d = d; e.is_irq = is_irq; e.exp = exp; e.due = due; e.name = name;
    q.push_back(e);
  endtask

  // Monitor: every entry is due on a specific edge and checked just after it.
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].due == cyc) begin
          if (q[i].is_irq) check(q[i].name, {31'b0, irq[q[i].d]}, q[i].exp);
          else             check(q[i].name, rdata[q[i].d], q[i].exp);
          q.delete(i);
        end else if (q[i].due < cyc) begin
          check({q[i].name, "_stale"}, 32'd0, 32'd1);
          q.delete(i);
        end
      end
    end
  end

  // All tasks start and end just after a negedge.
  task automatic rd(input int d, input logic [1:0] a, input logic [31:0] exp, input string name);
    cs[d] = 1'b1; wn[d] = 1'b1; addr[d] = a;
    push(d, 1'b0, exp, cyc + 1, name);
    @(negedge clk);
    cs[d] = 1'b0;
  endtask

  task automatic rd_idle(input int d, input string name);
    push(d, 1'b0, 32'd0, cyc + 1, name);
    @(negedge clk);
  endtask

  task automatic wr(input int d, input logic [1:0] a, input logic [31:0] data);
    cs[d] = 1'b1; wn[d] = 1'b0; addr[d] = a; wd[d] = data;
    @(negedge clk);
    cs[d] = 1'b0; wn[d] = 1'b1;
  endtask

  task automatic exp_irq(input int d, input logic e, input int due, input string name);
    push(d, 1'b1, {31'b0, e}, due, name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      cs[d] = 1'b0; wn[d] = 1'b1; addr[d] = 2'd0; wd[d] = 32'd0;
    end
    in_a = 8'hFF; in_b = 8'h00; in_c = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset with inputs high: no spurious capture, DATA visible from cycle 3
    exp_irq(0, 1'b0, cyc + 1, "rst_irq");
    rd(0, ADDR_DATA, 32'h00, "rst_data_e1");
    rd(0, ADDR_DATA, 32'h00, "rst_data_e2");
    rd(0, ADDR_DATA, 32'hFF, "rst_data_e3");
    repeat (2) @(negedge clk);
    rd(0, ADDR_EDGECAP, 32'h00, "rst_no_spurious");
    rd(0, ADDR_IRQMASK, 32'h00, "rst_mask");
    in_a = 8'h00;
    repeat (5) @(negedge clk);
    rd(0, ADDR_EDGECAP, 32'h00, "fall_ignored");

    // Rising edge on bit 3, edge-mode IRQ
    wr(0, ADDR_IRQMASK, 32'hABCD_EF08);
    rd(0, ADDR_IRQMASK, 32'h08, "mask_upper_zero");
    in_a = 8'h08;
    c0 = cyc + 1;
    exp_irq(0, 1'b0, c0 + 1, "b3_irq_t1");
    exp_irq(0, 1'b0, c0 + 2, "b3_irq_t2");
    exp_irq(0, 1'b1, c0 + 3, "b3_irq_t3");
    repeat (2) @(negedge clk);
    rd(0, ADDR_EDGECAP, 32'h00, "b3_cap_pre_t2");
    rd(0, ADDR_EDGECAP, 32'h08, "b3_cap_t2");
    exp_irq(0, 1'b1, cyc + 1, "b3_irq_at_clr");
    exp_irq(0, 1'b0, cyc + 2, "b3_irq_after_clr");
    wr(0, ADDR_EDGECAP, 32'h08);
    rd(0, ADDR_EDGECAP, 32'h00, "b3_cap_cleared");
    rd(0, ADDR_DATA, 32'h08, "b3_data");
    rd_idle(0, "cs_low_zero");
    wr(0, 2'd1, 32'hFF);
    rd(0, 2'd1, 32'h00, "reserved");

    // Same-cycle clear and edge on bit 0
    in_a = 8'h09;
    repeat (2) @(negedge clk);
    exp_irq(0, 1'b0, cyc + 1, "b0_unmasked_irq");
    wr(0, ADDR_EDGECAP, 32'h01);
    rd(0, ADDR_EDGECAP, 32'h01, "set_beats_clr");
    wr(0, ADDR_EDGECAP, 32'h01);
    rd(0, ADDR_EDGECAP, 32'h00, "b0_cleared");

    // Level mode: 10-cycle pulse, irq follows two cycles later
    wr(1, ADDR_IRQMASK, 32'h01);
    in_b = 8'h01;
    c0 = cyc + 1;
    for (int k = 1; k <= 12; k++)
      exp_irq(1, (k >= 2 && k <= 11), c0 + k, $sformatf("lvl_irq_%0d", k));
    repeat (10) @(negedge clk);
    in_b = 8'h00;
    repeat (4) @(negedge clk);
    rd(1, ADDR_EDGECAP, 32'h01, "lvl_cap");
    in_b = 8'h01;
    repeat (4) @(negedge clk);
    exp_irq(1, 1'b1, cyc + 1, "lvl_mask_at_wr");
    exp_irq(1, 1'b0, cyc + 2, "lvl_masked");
    wr(1, ADDR_IRQMASK, 32'h00);
    in_b = 8'h00;

    // WIDTH=1 any-edge: both edges captured, each surviving a clear
    wr(2, ADDR_IRQMASK, 32'hFFFF_FFFF);
    rd(2, ADDR_IRQMASK, 32'h01, "any_mask");
    in_c = 1'b1;
    c0 = cyc + 1;
    exp_irq(2, 1'b0, c0 + 2, "any_rise_irq_t2");
    exp_irq(2, 1'b1, c0 + 3, "any_rise_irq_t3");
    repeat (2) @(negedge clk);
    rd(2, ADDR_EDGECAP, 32'h0, "any_cap_pre");
    rd(2, ADDR_EDGECAP, 32'h1, "any_rise_cap");
    exp_irq(2, 1'b1, cyc + 1, "any_irq_at_clr");
    exp_irq(2, 1'b0, cyc + 2, "any_irq_clr");
    wr(2, ADDR_EDGECAP, 32'h1);
    rd(2, ADDR_EDGECAP, 32'h0, "any_cleared");
    in_c = 1'b0;
    repeat (2) @(negedge clk);
    exp_irq(2, 1'b0, cyc + 1, "any_fall_irq_t2");
    exp_irq(2, 1'b1, cyc + 2, "any_fall_irq_t3");
    wr(2, ADDR_EDGECAP, 32'h1);
    rd(2, ADDR_EDGECAP, 32'h1, "any_fall_cap");
    rd(2, ADDR_DATA, 32'h0, "any_data");

    // Asynchronous reset while EDGECAP = 5A and irq = 1
    in_a = 8'h00;
    repeat (4) @(negedge clk);
    wr(0, ADDR_EDGECAP, 32'hFF);
    in_a = 8'h5A;
    repeat (5) @(negedge clk);
    exp_irq(0, 1'b1, cyc + 1, "pre_rst_irq");
    rd(0, ADDR_EDGECAP, 32'h5A, "pre_rst_cap");
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_irq", {31'b0, irq[0]}, 32'd0);
    check("async_rst_rdata", rdata[0], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    exp_irq(0, 1'b0, cyc + 1, "post_rst_irq");
    rd(0, ADDR_EDGECAP, 32'h00, "post_rst_cap");
    rd(0, ADDR_IRQMASK, 32'h00, "post_rst_mask");
    rd(0, ADDR_DATA, 32'h5A, "post_rst_data");

    repeat (3) @(negedge clk);
    if (q.size() != 0) check("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
